// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// Turns a simple request strobe into APB SETUP/ACCESS transfers towards one of
// NUM_SLAVES completers, decoded from the top address bits. Completion is
// reported with a registered one-cycle done pulse, plus err and captured RDATA.
//
// Optional feature (compile-time macro): APB_TIMEOUT_EN
//   defined   : an ACCESS phase that waits TIMEOUT_CYCLES cycles without PREADY
//               is completed by the bridge with err = 1 (RDATA = 0 on reads).
//   undefined : ACCESS waits for PREADY indefinitely; TIMEOUT_CYCLES is unused.
//
// Ports
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   transfer               request strobe (sampled in IDLE and on completion)
//   SWRITE/SADDR/SWDATA/
//   SSTRB/SPROT            request fields
//   PSEL..PPROT            APB requester outputs (PSEL one-hot)
//   PREADY/PSLVERR/PRDATA  per-completer inputs, PRDATA flattened by index
//   RDATA                  read data captured on read completion
//   done, err              completion pulse; err only meaningful with done
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic                             transfer,
    input  logic                             SWRITE,
    input  logic [ADDR_WIDTH-1:0]            SADDR,
    input  logic [DATA_WIDTH-1:0]            SWDATA,
    input  logic [DATA_WIDTH/8-1:0]          SSTRB,
    input  logic [2:0]                       SPROT,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    output logic [2:0]                       PPROT,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    output logic [DATA_WIDTH-1:0]            RDATA,
    output logic                             done,
    output logic                             err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SEL_BITS   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_dw
        $error("apb_master_bridge: DATA_WIDTH must be 8, 16 or 32");
    end
    if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_ns
        $error("apb_master_bridge: NUM_SLAVES must be 1..16");
    end
    if (ADDR_WIDTH < SEL_BITS) begin : g_bad_aw
        $error("apb_master_bridge: ADDR_WIDTH must cover the select bits");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
        logic [2:0]            prot;
    } req_t;

    state_t                state_q, state_d;
    req_t                  req_q, req_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [SEL_BITS-1:0]   idx;
    logic                  ready_sel;
    logic                  slverr_sel;
    logic [DATA_WIDTH-1:0] rdata_sel;
    logic                  timeout;
    logic                  capture;

    assign idx = req_q.addr[ADDR_WIDTH-1 -: SEL_BITS];

    // Completer mux. An index with no matching completer falls through to the
    // defaults: ready=1 and slverr=1 end the transfer in its first ACCESS
    // cycle with an error, and read data reads as zero.
    always_comb begin
        ready_sel  = 1'b1;
        slverr_sel = 1'b1;
        rdata_sel  = '0;
        PSEL       = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx == SEL_BITS'(i)) begin
                ready_sel  = PREADY[i];
                slverr_sel = PSLVERR[i];
                rdata_sel  = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
                PSEL[i]    = (state_q != IDLE);
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counts not-ready ACCESS cycles; the TIMEOUT_CYCLES-th one ends the
    // transfer instead of incrementing.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        timeout   = 1'b0;
        if (state_q == SETUP) begin
            tmo_cnt_d = '0;
        end else if (state_q == ACCESS && !ready_sel) begin
            if (tmo_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) tmo_cnt_q <= '0;
        else          tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                capture = transfer;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (ready_sel || timeout) begin
                    done_d = 1'b1;
                    err_d  = timeout | slverr_sel;
                    if (!req_q.write) rdata_d = timeout ? '0 : rdata_sel;
                    // Back-to-back: go straight to SETUP without an IDLE cycle.
                    capture = transfer;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            state_d     = SETUP;
            req_d.write = SWRITE;
            req_d.addr  = SADDR;
            req_d.wdata = SWDATA;
            req_d.strb  = SWRITE ? SSTRB : '0;
            req_d.prot  = SPROT;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign PENABLE = (state_q == ACCESS);
    assign PWRITE  = req_q.write;
    assign PADDR   = req_q.addr;
    assign PWDATA  = req_q.wdata;
    assign PSTRB   = req_q.strb;
    assign PPROT   = req_q.prot;
    assign RDATA   = rdata_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Directed bench for apb_master_bridge. A 4-completer instance covers normal
// writes/reads, wait states, back-to-back transfers, slave errors and reset
// abort; a 3-completer instance covers the unmapped-index decode error.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

    logic         PCLK;
    logic         PRESETn;
    logic         transfer, SWRITE;
    logic [31:0]  SADDR, SWDATA;
    logic [3:0]   SSTRB;
    logic [2:0]   SPROT;
    logic [3:0]   PSEL;
    logic         PENABLE, PWRITE;
    logic [31:0]  PADDR, PWDATA;
    logic [3:0]   PSTRB;
    logic [2:0]   PPROT;
    logic [3:0]   PREADY, PSLVERR;
    logic [127:0] PRDATA;
    logic [31:0]  RDATA;
    logic         done, err;

    logic         t3_transfer, t3_write;
    logic [31:0]  t3_addr, t3_wdata;
    logic [3:0]   t3_strb;
    logic [2:0]   t3_prot;
    logic [2:0]   PSEL3, PREADY3, PSLVERR3;
    logic [95:0]  PRDATA3;
    logic         PENABLE3;
    logic [31:0]  RDATA3;
    logic         done3, err3;
    logic         u3_unused_pwrite;
    logic [31:0]  u3_unused_paddr, u3_unused_pwdata;
    logic [3:0]   u3_unused_pstrb;
    logic [2:0]   u3_unused_pprot;

    int vec_cnt     = 0;
    int miscompares = 0;

    apb_master_bridge dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .transfer(transfer), .SWRITE(SWRITE),
        .SADDR(SADDR), .SWDATA(SWDATA), .SSTRB(SSTRB), .SPROT(SPROT),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .PRDATA(PRDATA), .RDATA(RDATA), .done(done), .err(err)
    );

    apb_master_bridge #(.NUM_SLAVES(3)) dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .transfer(t3_transfer), .SWRITE(t3_write),
        .SADDR(t3_addr), .SWDATA(t3_wdata), .SSTRB(t3_strb), .SPROT(t3_prot),
        .PSEL(PSEL3), .PENABLE(PENABLE3), .PWRITE(u3_unused_pwrite),
        .PADDR(u3_unused_paddr), .PWDATA(u3_unused_pwdata), .PSTRB(u3_unused_pstrb),
        .PPROT(u3_unused_pprot), .PREADY(PREADY3), .PSLVERR(PSLVERR3),
        .PRDATA(PRDATA3), .RDATA(RDATA3), .done(done3), .err(err3)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        PRESETn = 1'b1;
        #1 PRESETn = 1'b0;
        #2;
        vec_cnt++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, RDATA, done, err} !== '0) begin
            miscompares++;
            $display("FAIL rst_outputs: got psel=%h pen=%b paddr=%h rdata=%h done=%b exp all 0",
                     PSEL, PENABLE, PADDR, RDATA, done);
        end
        vec_cnt++;
        if ({PSEL3, PENABLE3, RDATA3, done3, err3} !== '0) begin
            miscompares++;
            $display("FAIL rst_outputs3: got psel=%h pen=%b rdata=%h exp all 0", PSEL3, PENABLE3, RDATA3);
        end
        tick();
        PRESETn = 1'b1;
    endtask

    // Slave 1, zero wait states; first request after reset release.
    task automatic test_write();
        transfer = 1'b1; SWRITE = 1'b1; SADDR = 32'h4000_0010; SWDATA = 32'hDEAD_BEEF;
        SSTRB = 4'hF; SPROT = 3'b010; PREADY = 4'b0010;
        tick();
        transfer = 1'b0;
        vec_cnt++;
        if ({PSEL, PENABLE, PWRITE} !== {4'b0010, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL wr_setup_ctl: got %b exp %b", {PSEL, PENABLE, PWRITE}, {4'b0010, 1'b0, 1'b1});
        end
        vec_cnt++;
        if ({PADDR, PWDATA, PSTRB, PPROT} !== {32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010}) begin
            miscompares++;
            $display("FAIL wr_setup_bus: got %h/%h/%h/%h exp 40000010/deadbeef/f/2", PADDR, PWDATA, PSTRB, PPROT);
        end
        tick();
        vec_cnt++;
        if ({PSEL, PENABLE, done} !== {4'b0010, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL wr_access: got %b exp %b", {PSEL, PENABLE, done}, {4'b0010, 1'b1, 1'b0});
        end
        tick();
        vec_cnt++;
        if ({done, err, PSEL, PENABLE} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
            miscompares++;
            $display("FAIL wr_done: got %b exp %b", {done, err, PSEL, PENABLE}, {1'b1, 1'b0, 4'b0000, 1'b0});
        end
        vec_cnt++;
        if ({PADDR, PWDATA, PWRITE, PSTRB} !== {32'h4000_0010, 32'hDEAD_BEEF, 1'b1, 4'hF}) begin
            miscompares++;
            $display("FAIL wr_idle_hold: got %h/%h/%b/%h exp 40000010/deadbeef/1/f", PADDR, PWDATA, PWRITE, PSTRB);
        end
        tick();
        vec_cnt++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_done_once: got %b exp 0", done);
        end
    endtask

    // Slave 3, three not-ready ACCESS cycles; other completers' signals noisy.
    task automatic test_read();
        PREADY = 4'b0001; PSLVERR = 4'b0010;
        PRDATA = {32'h1234_5678, 32'hAAAA_5555, 32'hBBBB_6666, 32'hCCCC_7777};
        transfer = 1'b1; SWRITE = 1'b0; SADDR = 32'hC000_0000; SWDATA = 32'h0;
        SSTRB = 4'hF; SPROT = 3'b001;
        tick();
        transfer = 1'b0;
        vec_cnt++;
        if ({PSEL, PENABLE, PWRITE, PSTRB} !== {4'b1000, 1'b0, 1'b0, 4'h0}) begin
            miscompares++;
            $display("FAIL rd_setup: got %b exp %b", {PSEL, PENABLE, PWRITE, PSTRB}, {4'b1000, 1'b0, 1'b0, 4'h0});
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            vec_cnt++;
            if ({PSEL, PENABLE, done} !== {4'b1000, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL rd_access%0d: got %b exp %b", k, {PSEL, PENABLE, done}, {4'b1000, 1'b1, 1'b0});
            end
            if (k == 4) PREADY = 4'b1000;
        end
        tick();
        vec_cnt++;
        if ({done, err, PENABLE, RDATA} !== {1'b1, 1'b0, 1'b0, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL rd_done: got done=%b err=%b pen=%b rdata=%h exp 1 0 0 12345678", done, err, PENABLE, RDATA);
        end
        PREADY = 4'b0000; PSLVERR = 4'b0000;
    endtask

    task automatic test_back_to_back();
        PREADY = 4'b1111;
        transfer = 1'b1; SWRITE = 1'b1; SADDR = 32'h0000_0100; SWDATA = 32'h1111_1111; SSTRB = 4'hF;
        tick();
        SADDR = 32'h8000_0200; SWDATA = 32'h2222_2222; SSTRB = 4'h3;
        vec_cnt++;
        if ({PSEL, PENABLE, PADDR} !== {4'b0001, 1'b0, 32'h0000_0100}) begin
            miscompares++;
            $display("FAIL b2b_setup_a: got psel=%b pen=%b paddr=%h exp 0001 0 00000100", PSEL, PENABLE, PADDR);
        end
        tick();
        vec_cnt++;
        if ({PSEL, PENABLE, PADDR, PWDATA} !== {4'b0001, 1'b1, 32'h0000_0100, 32'h1111_1111}) begin
            miscompares++;
            $display("FAIL b2b_access_a: got psel=%b pen=%b paddr=%h pwdata=%h exp 0001 1 00000100 11111111",
                     PSEL, PENABLE, PADDR, PWDATA);
        end
        tick();
        transfer = 1'b0;
        vec_cnt++;
        if ({done, err, PENABLE, PSEL, PADDR, PWDATA, PSTRB} !==
            {1'b1, 1'b0, 1'b0, 4'b0100, 32'h8000_0200, 32'h2222_2222, 4'h3}) begin
            miscompares++;
            $display("FAIL b2b_setup_b: got done=%b pen=%b psel=%b paddr=%h pwdata=%h pstrb=%h exp 1 0 0100 80000200 22222222 3",
                     done, PENABLE, PSEL, PADDR, PWDATA, PSTRB);
        end
        tick();
        vec_cnt++;
        if ({PENABLE, done, PSEL} !== {1'b1, 1'b0, 4'b0100}) begin
            miscompares++;
            $display("FAIL b2b_access_b: got %b exp %b", {PENABLE, done, PSEL}, {1'b1, 1'b0, 4'b0100});
        end
        tick();
        vec_cnt++;
        if ({done, err, PSEL, PENABLE, RDATA} !== {1'b1, 1'b0, 4'b0000, 1'b0, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL b2b_done_b: got done=%b psel=%b pen=%b rdata=%h exp 1 0000 0 12345678",
                     done, PSEL, PENABLE, RDATA);
        end
        tick();
        vec_cnt++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done_once: got %b exp 0", done);
        end
        PREADY = 4'b0000;
    endtask

    task automatic test_slverr();
        PREADY = 4'b0100; PSLVERR = 4'b0100;
        transfer = 1'b1; SWRITE = 1'b1; SADDR = 32'h8000_0000; SWDATA = 32'h0000_00FF; SSTRB = 4'h1;
        tick();
        transfer = 1'b0;
        tick();
        tick();
        vec_cnt++;
        if ({done, err} !== 2'b11) begin
            miscompares++;
            $display("FAIL slverr_done: got %b exp 11", {done, err});
        end
        tick();
        vec_cnt++;
        if ({done, err} !== 2'b00) begin
            miscompares++;
            $display("FAIL slverr_clear: got %b exp 00", {done, err});
        end
        PREADY = 4'b0000; PSLVERR = 4'b0000;
    endtask

    // 3-completer instance: index 3 has no completer behind it.
    task automatic test_decode_err();
        t3_transfer = 1'b1; t3_write = 1'b0; t3_addr = 32'h0000_0000;
        PREADY3 = 3'b001; PSLVERR3 = 3'b110;
        PRDATA3 = {32'h9999_0000, 32'h7777_3333, 32'h5555_AAAA};
        tick();
        t3_transfer = 1'b0;
        vec_cnt++;
        if ({PSEL3, PENABLE3} !== {3'b001, 1'b0}) begin
            miscompares++;
            $display("FAIL dec_ok_setup: got %b exp 0010", {PSEL3, PENABLE3});
        end
        tick();
        tick();
        vec_cnt++;
        if ({done3, err3, RDATA3} !== {1'b1, 1'b0, 32'h5555_AAAA}) begin
            miscompares++;
            $display("FAIL dec_ok_done: got done=%b err=%b rdata=%h exp 1 0 5555aaaa", done3, err3, RDATA3);
        end
        t3_transfer = 1'b1; t3_addr = 32'hC000_0000; PREADY3 = 3'b000; PSLVERR3 = 3'b000;
        tick();
        t3_transfer = 1'b0;
        vec_cnt++;
        if ({PSEL3, PENABLE3} !== {3'b000, 1'b0}) begin
            miscompares++;
            $display("FAIL dec_err_setup: got %b exp 0000", {PSEL3, PENABLE3});
        end
        tick();
        vec_cnt++;
        if ({PSEL3, PENABLE3, done3} !== {3'b000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL dec_err_access: got %b exp 00010", {PSEL3, PENABLE3, done3});
        end
        tick();
        vec_cnt++;
        if ({done3, err3, RDATA3, PENABLE3} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL dec_err_done: got done=%b err=%b rdata=%h pen=%b exp 1 1 00000000 0",
                     done3, err3, RDATA3, PENABLE3);
        end
    endtask

    task automatic test_reset_mid_access();
        PREADY = 4'b0000;
        transfer = 1'b1; SWRITE = 1'b1; SADDR = 32'h0000_0040; SWDATA = 32'h0BAD_F00D; SSTRB = 4'hF;
        tick();
        transfer = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            vec_cnt++;
            if ({PENABLE, PSEL, done} !== {1'b1, 4'b0001, 1'b0}) begin
                miscompares++;
                $display("FAIL stall%0d: got %b exp %b", k, {PENABLE, PSEL, done}, {1'b1, 4'b0001, 1'b0});
            end
        end
        // Ready arrives together with reset: the edge that would complete it is inside reset.
        PRESETn = 1'b0;
        PREADY  = 4'b0001;
        #2;
        vec_cnt++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, RDATA, done, err} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_access: got psel=%h pen=%b pwrite=%b paddr=%h pwdata=%h rdata=%h exp all 0",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, RDATA);
        end
        tick();
        PRESETn = 1'b1;
        PREADY  = 4'b0000;
        for (int k = 1; k <= 2; k++) begin
            tick();
            vec_cnt++;
            if ({done, PENABLE, PSEL} !== {1'b0, 1'b0, 4'b0000}) begin
                miscompares++;
                $display("FAIL rst_no_done%0d: got %b exp 000000", k, {done, PENABLE, PSEL});
            end
        end
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        PREADY = 4'b0000;
        transfer = 1'b1; SWRITE = 1'b0; SADDR = 32'h0000_0000; SSTRB = 4'hF;
        tick();
        transfer = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            vec_cnt++;
            if ({PENABLE, done} !== 2'b10) begin
                miscompares++;
                $display("FAIL tmo_wait%0d: got %b exp 10", k, {PENABLE, done});
            end
        end
        tick();
        vec_cnt++;
        if ({done, err, PSEL, PENABLE, RDATA} !== {1'b1, 1'b1, 4'b0000, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL tmo_done: got done=%b err=%b psel=%b pen=%b rdata=%h exp 1 1 0000 0 00000000",
                     done, err, PSEL, PENABLE, RDATA);
        end
    endtask
`endif

    initial begin
        transfer = 1'b0; SWRITE = 1'b0; SADDR = '0; SWDATA = '0; SSTRB = '0; SPROT = '0;
        PREADY = '0; PSLVERR = '0; PRDATA = '0;
        t3_transfer = 1'b0; t3_write = 1'b0; t3_addr = '0; t3_wdata = '0; t3_strb = '0; t3_prot = '0;
        PREADY3 = '0; PSLVERR3 = '0; PRDATA3 = '0;

        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_slverr();
        test_decode_err();
        test_reset_mid_access();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
